// File: rtl/pts_shift_tx.sv
// Parallel-to-serial transmitter: ready/valid word load, one bit per shift_enable strobe, idle-high line.
// Optional trailing even-parity bit when PTS_PARITY_EN is defined.
module pts_shift_tx #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] par_in,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic                shift_enable,
    output logic                serial_out,
    output logic                busy,
    output logic                done
);

    localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BITS - 1);

`ifdef PTS_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] shreg_q, shreg_d;
    logic [NUM_BITS-1:0] shifted;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                serial_q, serial_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                first_bit;
    logic                next_bit;
`ifdef PTS_PARITY_EN
    logic                parity_q, parity_d;
`endif

    // Register moves toward the output end; the vacated end refills with ones.
    always_comb begin
        if (SHIFT_MSB) begin
            shifted   = {shreg_q[NUM_BITS-2:0], 1'b1};
            next_bit  = shifted[NUM_BITS-1];
            first_bit = par_in[NUM_BITS-1];
        end else begin
            shifted   = {1'b1, shreg_q[NUM_BITS-1:1]};
            next_bit  = shifted[0];
            first_bit = par_in[0];
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef PTS_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (load_valid) begin
                    shreg_d  = par_in;
                    cnt_d    = '0;
                    serial_d = first_bit;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
`ifdef PTS_PARITY_EN
                    parity_d = ^par_in;
`endif
                end
            end
            SHIFT: begin
                if (shift_enable) begin
                    if (cnt_q != LAST_CNT) begin
                        shreg_d  = shifted;
                        serial_d = next_bit;
                        cnt_d    = cnt_q + CW'(1);
                    end else begin
`ifdef PTS_PARITY_EN
                        serial_d = parity_q;
                        state_d  = PARITY;
`else
                        state_d  = IDLE;
                        serial_d = 1'b1;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        shreg_d  = '1;
`endif
                    end
                end
            end
`ifdef PTS_PARITY_EN
            PARITY: begin
                if (shift_enable) begin
                    state_d  = IDLE;
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    shreg_d  = '1;
                end
            end
`endif
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            shreg_q  <= '1;
            cnt_q    <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PTS_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef PTS_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign load_ready = (state_q == IDLE);
    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pts_shift_tx.sv
// Scoreboard bench for pts_shift_tx: an MSB-first and an LSB-first instance share one clock.
// Expected bit streams are queued at load time and popped as the line is observed.
module tb_pts_shift_tx;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] par_m, par_l;
    logic       lv_m, lv_l, se_m, se_l;
    logic       rdy_m, so_m, busy_m, done_m;
    logic       rdy_l, so_l, busy_l, done_l;

    int checks = 0;
    int failures = 0;
    bit exp_q[$];
    bit cur;   // 0 = MSB-first instance, 1 = LSB-first instance

    always #5 clk = ~clk;

    pts_shift_tx #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) dut_m (
        .clk(clk), .n_rst(n_rst), .par_in(par_m), .load_valid(lv_m), .load_ready(rdy_m),
        .shift_enable(se_m), .serial_out(so_m), .busy(busy_m), .done(done_m)
    );

    pts_shift_tx #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) dut_l (
        .clk(clk), .n_rst(n_rst), .par_in(par_l), .load_valid(lv_l), .load_ready(rdy_l),
        .shift_enable(se_l), .serial_out(so_l), .busy(busy_l), .done(done_l)
    );

    logic o_so, o_busy, o_done, o_rdy;
    assign o_so   = cur ? so_l   : so_m;
    assign o_busy = cur ? busy_l : busy_m;
    assign o_done = cur ? done_l : done_m;
    assign o_rdy  = cur ? rdy_l  : rdy_m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit lv, input logic [7:0] par, input bit se);
        if (cur) begin lv_l = lv; par_l = par; se_l = se; end
        else     begin lv_m = lv; par_m = par; se_m = se; end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (o_so !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s: so=%b busy=%b done=%b rdy=%b, required so=1 busy=0 done=0 rdy=1",
                     name, o_so, o_busy, o_done, o_rdy);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) exp_q.push_back(cur ? w[i] : w[7-i]);
`ifdef PTS_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    task automatic accept(input logic [7:0] w);
        checks++;
        if (o_rdy !== 1'b1) begin
            failures++;
            $display("FAIL load_ready_before_load: got %b required 1", o_rdy);
        end
        drive(1'b1, w, 1'b0);
        push_word(w);
        tick();
        drive(1'b0, w, 1'b0);
    endtask

    // Pops every queued bit, holding each for 'period' cycles; strobe on the last cycle of each.
    task automatic shift_out(input string name, input int period, input bit intrude);
        bit e;
        int idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int c = 0; c < period; c++) begin
                if (intrude) drive(1'b1, 8'hFF, c == period - 1);
                else         drive(1'b0, 8'h00, c == period - 1);
                checks++;
                if (o_so !== e || o_busy !== 1'b1 || o_done !== 1'b0 || o_rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s bit%0d cyc%0d: so=%b busy=%b done=%b rdy=%b, required so=%b busy=1 done=0 rdy=0",
                             name, idx, c, o_so, o_busy, o_done, o_rdy, e);
                end
                tick();
            end
            idx++;
        end
        if (intrude) drive(1'b1, 8'hFF, 1'b0);
        else         drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (o_so !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b1 || o_rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s completion: so=%b busy=%b done=%b rdy=%b, required so=1 busy=0 done=1 rdy=1",
                     name, o_so, o_busy, o_done, o_rdy);
        end
        $display("word %s complete", name);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        cur = 1'b0; drive(1'b0, 8'h00, 1'b0);
        cur = 1'b1; drive(1'b0, 8'h00, 1'b0);
        repeat (3) tick();
        cur = 1'b0; check_idle("reset_hold_msb");
        cur = 1'b1; check_idle("reset_hold_lsb");
        n_rst = 1'b1;
        repeat (2) tick();
        cur = 1'b0; check_idle("after_release_msb");
    endtask

    task automatic test_msb_continuous();
        cur = 1'b0;
        accept(8'h96);
        shift_out("msb_96", 1, 1'b0);
        tick();
        check_idle("msb_done_one_cycle");
    endtask

    task automatic test_lsb_slow();
        cur = 1'b1;
        accept(8'h1D);
        shift_out("lsb_1d", 4, 1'b0);
        tick();
        check_idle("lsb_done_one_cycle");
    endtask

    task automatic test_back_to_back();
        cur = 1'b0;
        accept(8'h96);
        shift_out("b2b_96", 1, 1'b1);
        push_word(8'hFF);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (o_busy !== 1'b1 || o_so !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept_after_done: busy=%b so=%b, required busy=1 so=1", o_busy, o_so);
        end
        shift_out("b2b_ff", 1, 1'b0);
        tick();
    endtask

    task automatic test_parity_words();
        cur = 1'b0;
        accept(8'h07);
        shift_out("msb_07", 1, 1'b0);
        tick();
        accept(8'h96);
        shift_out("msb_96_par", 2, 1'b0);
        tick();
    endtask

    task automatic test_idle_strobe();
        cur = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
            check_idle("idle_strobe");
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_midword();
        cur = 1'b0;
        accept(8'h96);
        drive(1'b0, 8'h00, 1'b1);
        repeat (2) tick();
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (o_so !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL midword_pre_reset: so=%b busy=%b, required so=0 busy=1", o_so, o_busy);
        end
        exp_q.delete();
        #1 n_rst = 1'b0;
        #1 check_idle("async_reset_midword");
        tick();
        n_rst = 1'b1;
        tick();
        drive(1'b0, 8'h00, 1'b1);
        repeat (3) tick();
        drive(1'b0, 8'h00, 1'b0);
        check_idle("no_resume_after_reset");
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL timeout: simulation exceeded time budget");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_msb_continuous();
        test_lsb_slow();
        test_back_to_back();
        test_parity_words();
        test_idle_strobe();
        test_reset_midword();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pts_shift_tx.md
# pts_shift_tx

Parameterizable parallel-to-serial transmitter: the sending end of the serial link whose receiving end is the serial-to-parallel shift register chain. It captures a parallel word through a ready/valid load handshake. It then shifts the word out one bit per `shift_enable` strobe, MSB- or LSB-first, and returns to an idle-high line with a one-cycle completion pulse. It sits between the packet/control logic that supplies words and the bit-rate strobe generator (a flex counter) that paces the line.

## Interface
Parameters:
- `NUM_BITS`, 8, data word width (2..32).
- `SHIFT_MSB`, 1, 1 = MSB first, 0 = LSB first.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `n_rst`  input  1  asynchronous, active-low reset.
- `par_in`  input  NUM_BITS  word to transmit; sampled only on an accepted load.
- `load_valid`  input  1  requester has a word on `par_in`.
- `load_ready`  output  1  transmitter can accept a word. Combinational from state: high only in IDLE.
- `shift_enable`  input  1  bit-period strobe; one bit advances per sampled high cycle.
- `serial_out`  output  1  registered serial line; idles high.
- `busy`  output  1  registered; high from accepted load until return to IDLE.
- `done`  output  1  registered one-cycle pulse on the edge that returns to IDLE.

## Operation
States:
- IDLE: `serial_out`=1, `load_ready`=1, `busy`=0.
  - On `load_valid` && `load_ready`: capture `par_in`, bit counter = 0, drive the first bit (bit NUM_BITS-1 if SHIFT_MSB, else bit 0), then go to SHIFT.
  - `shift_enable` is ignored in IDLE.
- SHIFT: `serial_out` holds the current bit. Each edge with `shift_enable`=1:
  - If counter < NUM_BITS-1: shift the register toward the output end, fill the vacated bit with 1, counter++.
  - If counter == NUM_BITS-1: go to PARITY if configured, else to IDLE with `done`=1 and `serial_out`=1.
- PARITY (only when the macro below is defined): `serial_out` = even-parity bit of the captured word, i.e. XOR of all NUM_BITS bits. The next `shift_enable` edge goes to IDLE with `done`=1 and `serial_out`=1.

Rules:
- `load_valid` is ignored outside IDLE. There is no back-to-back load on the completion edge; the earliest next load is the following cycle.
- `par_in` changes after capture do not affect the word in flight.
- Counter width is $clog2(NUM_BITS). The counter never wraps; it is cleared on every load and on reset.
- `shift_enable` held high continuously gives one bit per clock.

Reset, applied at any time including mid-word:
- state = IDLE, `serial_out`=1, `busy`=0, `done`=0, counter=0, shift register all ones.
- `load_ready`=1 once reset is released.
- The partial word is discarded; nothing resumes after reset.

## Timing
- Load accepted at edge k: first bit on `serial_out` and `busy`=1 after edge k.
- Bit i (0-based in transmit order) is valid after edge k and the i-th subsequent `shift_enable` edge.
- Completion edge: the NUM_BITS-th `shift_enable` edge after load, or the (NUM_BITS+1)-th with parity.
  - After it: `serial_out`=1, `busy`=0, `done`=1 for exactly one cycle, `load_ready`=1.
- Minimum word time is NUM_BITS+1 cycles (NUM_BITS+2 with parity) including the idle cycle before the next load.

## Configuration
- `PTS_PARITY_EN` defined: PARITY state is compiled in, and one even-parity bit follows the data bits.
- Not defined: no PARITY state; completion follows the last data bit. Port list is identical in both builds.

## Test plan
- Reset, then hold: `serial_out`=1, `busy`=0, `done`=0, `load_ready`=1. Assert `n_rst` low mid-word (after bit 3) -> the same values appear immediately, not waiting for a clock edge.
- NUM_BITS=8, SHIFT_MSB=1, `par_in`=8'h96, `shift_enable` held high -> `serial_out` = 1,0,0,1,0,1,1,0, then 1. `done` pulses one cycle after bit 7.
- SHIFT_MSB=0, `par_in`=8'h1D, `shift_enable` every 4th cycle -> `serial_out` = 1,0,1,1,1,0,0,0, each bit held 4 cycles. `busy` stays high for the whole word.
- During SHIFT, assert `load_valid` with `par_in`=8'hFF -> `load_ready`=0, the word in flight is unchanged, and the load is accepted the first cycle after `done`.
- `PTS_PARITY_EN` defined:
  - `par_in`=8'h07, MSB-first -> 0,0,0,0,0,1,1,1, then parity 1, then `done`.
  - `par_in`=8'h96 -> parity 0.
- `shift_enable` pulsed while in IDLE -> no state change, `serial_out` stays 1, no `done`.
